track_position_ctrl: RTL and testbench
======================================

Name: track_position_ctrl

Overview:
Closed-count position controller directly upstream of the track stepper driver. It accepts absolute target positions (in steps) and homing requests from the main kitchen-helper FSM. It produces the level-type move_o/back_o pair consumed by the track driver's move_i/back_i. It tracks the carriage position by counting step periods on the same time base as the driver's divided step clock.

Parameters:
POS_W, 10, width of position/target values in steps
MAX_POS, 800, highest legal target position (steps)
STEP_CYCLES, 500000, clk cycles per motor step (matches 10 ms driver step at 50 MHz)
SETTLE_STEPS, 4, step periods the motor is held idle after each move before done
HOME_TIMEOUT, 832, step periods allowed for homing before error (MAX_POS+32)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active-low
cmd_valid_i  in  1  target command valid
cmd_ready_o  out  1  high in IDLE only; command accepted when valid&&ready
cmd_pos_i  in  POS_W  absolute target position, sampled on accept
home_i  in  1  homing request, sampled in IDLE only
limit_i  in  1  home limit switch, active-high, asynchronous (2-FF synchronised internally)
move_o  out  1  to driver move_i; motor enabled
back_o  out  1  to driver back_i; 1 = toward home (position decreasing)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse on successful completion of move or homing
err_o  out  1  one-cycle pulse on rejected command or homing timeout
homed_o  out  1  position valid; set by successful homing
pos_o  out  POS_W  current position count

Behaviour:
- Reset (rst_n low at posedge clk), mid-operation included: state=IDLE, move_o=0, back_o=0, busy_o=0, done_o=0, err_o=0, homed_o=0, pos_o=0, step counter=0, synchroniser flops=0. cmd_ready_o=1 from the first cycle after reset release.
- Step tick: free-running counter 0..STEP_CYCLES-1 that restarts at 0 on every state entry. Tick fires when the counter wraps. It is used only in HOMING, FWD, BWD and SETTLE.
- States: IDLE, HOMING, FWD, BWD, SETTLE.
- IDLE:
  - Priority: home_i > cmd_valid_i.
  - home_i=1 -> HOMING.
  - Otherwise on cmd accept:
    - cmd_pos_i > MAX_POS, or homed_o=0 -> err_o pulse next cycle, stay IDLE.
    - cmd_pos_i == pos_o -> done_o pulse next cycle, stay IDLE, no motor motion.
    - cmd_pos_i > pos_o -> FWD.
    - cmd_pos_i < pos_o -> BWD.
  - The target is latched on accept. cmd_valid_i/home_i are ignored outside IDLE.
- HOMING:
  - Outputs: move_o=1, back_o=1.
  - Synchronised limit high -> pos_o=0, homed_o=1, go to SETTLE.
  - HOME_TIMEOUT ticks elapsed without limit -> err_o pulse, homed_o=0, move_o=0, go to IDLE.
  - Limit already high on entry -> exits on the first cycle it is seen (2-3 cycles); pos_o=0.
- FWD:
  - Outputs: move_o=1, back_o=0.
  - Each tick: pos_o+1.
  - The tick that makes pos_o == target -> SETTLE in the same cycle pos_o updates.
- BWD:
  - Outputs: move_o=1, back_o=1.
  - Each tick: pos_o-1; same exit rule as FWD.
  - Synchronised limit high in BWD -> pos_o forced 0, go to SETTLE (target overridden).
- SETTLE:
  - Outputs: move_o=0; back_o holds its last value (the driver keeps the coil pattern).
  - After SETTLE_STEPS ticks -> done_o pulse, go to IDLE.
- Output timing: move_o/back_o are registered and change in the cycle the state register changes. back_o changes only while move_o=0 or in the same cycle move_o rises.
- Arithmetic: pos_o never wraps. FWD cannot exceed MAX_POS (target is bounded) and BWD cannot go below 0 (target ≥ 0). A defensive saturation at 0/MAX_POS is required.
- done_o and err_o are never high in the same cycle.

Test Plan:
- Bench parameters: STEP_CYCLES=4, MAX_POS=20, SETTLE_STEPS=2, HOME_TIMEOUT=30.
- Reset then cmd_pos_i=5 without homing -> err_o one pulse, move_o stays 0, pos_o=0, homed_o=0.
- home_i, limit_i raised after 24 clk -> move_o=1/back_o=1 until ~2 clk after limit, pos_o=0, homed_o=1, done_o pulse 8 clk after move_o falls.
- Homed, cmd_pos_i=7 -> move_o=1/back_o=0 for 28 clk, pos_o steps 1..7, then done_o pulse 8 clk later. Then cmd_pos_i=3 -> back_o=1, pos_o=3 after 16 clk, done_o.
- cmd_pos_i=3 while pos_o=3 -> done_o next cycle, move_o never asserts. cmd_pos_i=21 -> err_o, pos_o unchanged.
- home_i with limit never asserted -> err_o after 120 clk, move_o=0, homed_o=0. rst_n low mid-FWD -> all outputs zero at the next posedge.
- Simultaneous home_i and cmd_valid_i in IDLE -> HOMING entered, command not accepted (cmd_ready_o drops next cycle, no err_o/done_o).

Source files
------------

// File: rtl/track_position_ctrl.sv
// Closed-count carriage position controller feeding the track stepper driver.
// It counts driver step periods to track position, and it handles homing against the limit switch.
module track_position_ctrl #(
  parameter int POS_W        = 10,
  parameter int MAX_POS      = 800,
  parameter int STEP_CYCLES  = 500000,
  parameter int SETTLE_STEPS = 4,
  parameter int HOME_TIMEOUT = 832
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [POS_W-1:0] cmd_pos_i,
  input  logic             home_i,
  input  logic             limit_i,
  output logic             move_o,
  output logic             back_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             homed_o,
  output logic [POS_W-1:0] pos_o
);

  localparam int CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int TMAX   = (HOME_TIMEOUT > SETTLE_STEPS) ? HOME_TIMEOUT : SETTLE_STEPS;
  localparam int TCNT_W = $clog2(TMAX + 1);
  localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOMING,
    ST_FWD,
    ST_BWD,
    ST_SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [POS_W-1:0]    target_q, target_d;
  logic                homed_q, homed_d;
  logic                move_q, move_d;
  logic                back_q, back_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                lim_meta_q, lim_meta_d;
  logic                lim_sync_q, lim_sync_d;

  logic                tick;
  logic [TCNT_W-1:0]   tick_inc;
  logic [POS_W-1:0]    pos_up;
  logic [POS_W-1:0]    pos_dn;

  assign tick     = (step_cnt_q == CNT_W'(STEP_CYCLES - 1));
  assign tick_inc = tick_cnt_q + TCNT_W'(1);
  // Saturating neighbours of the current count.
  assign pos_up   = (pos_q >= MAX_POS_V) ? MAX_POS_V : pos_q + POS_W'(1);
  assign pos_dn   = (pos_q == '0) ? '0 : pos_q - POS_W'(1);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    target_d   = target_q;
    homed_d    = homed_q;
    tick_cnt_d = tick_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    lim_meta_d = limit_i;
    lim_sync_d = lim_meta_q;

    case (state_q)
      ST_IDLE: begin
        if (home_i) begin
          state_d = ST_HOMING;
        end else if (cmd_valid_i) begin
          if ((cmd_pos_i > MAX_POS_V) || !homed_q) begin
            err_d = 1'b1;
          end else if (cmd_pos_i == pos_q) begin
            done_d = 1'b1;
          end else begin
            target_d = cmd_pos_i;
            state_d  = (cmd_pos_i > pos_q) ? ST_FWD : ST_BWD;
          end
        end
      end
      ST_HOMING: begin
        if (lim_sync_q) begin
          pos_d   = '0;
          homed_d = 1'b1;
          state_d = ST_SETTLE;
        end else if (tick) begin
          if (tick_inc == TCNT_W'(HOME_TIMEOUT)) begin
            err_d   = 1'b1;
            homed_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      ST_FWD: begin
        if (tick) begin
          pos_d = pos_up;
          if (pos_up >= target_q) state_d = ST_SETTLE;
        end
      end
      ST_BWD: begin
        // The home switch is authoritative: it wins over the latched target.
        if (lim_sync_q) begin
          pos_d   = '0;
          state_d = ST_SETTLE;
        end else if (tick) begin
          pos_d = pos_dn;
          if (pos_dn <= target_q) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tick) begin
          if (tick_inc == TCNT_W'(SETTLE_STEPS)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Step time base restarts on every state entry.
    if (state_d != state_q) begin
      step_cnt_d = '0;
      tick_cnt_d = '0;
    end else begin
      step_cnt_d = tick ? '0 : step_cnt_q + CNT_W'(1);
    end

    move_d = (state_d == ST_HOMING) || (state_d == ST_FWD) || (state_d == ST_BWD);
    // Direction only moves with motion; SETTLE/IDLE keep the coil pattern.
    case (state_d)
      ST_HOMING, ST_BWD: back_d = 1'b1;
      ST_FWD:            back_d = 1'b0;
      default:           back_d = back_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      tick_cnt_q <= '0;
      pos_q      <= '0;
      target_q   <= '0;
      homed_q    <= 1'b0;
      move_q     <= 1'b0;
      back_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lim_meta_q <= 1'b0;
      lim_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      pos_q      <= pos_d;
      target_q   <= target_d;
      homed_q    <= homed_d;
      move_q     <= move_d;
      back_q     <= back_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lim_meta_q <= lim_meta_d;
      lim_sync_q <= lim_sync_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign move_o      = move_q;
  assign back_o      = back_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign homed_o     = homed_q;
  assign pos_o       = pos_q;

endmodule

// File: tb/tb_track_position_ctrl.sv
// Directed bench for track_position_ctrl with a done/err response scoreboard.
// Stimulus pushes the expected outcome; a monitor pops it on every done_o/err_o pulse.
module tb_track_position_ctrl;

  localparam int POS_W        = 10;
  localparam int MAX_POS      = 20;
  localparam int STEP_CYCLES  = 4;
  localparam int SETTLE_STEPS = 2;
  localparam int HOME_TIMEOUT = 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [POS_W-1:0] cmd_pos_i = '0;
  logic             home_i = 1'b0;
  logic             limit_i = 1'b0;
  logic             move_o;
  logic             back_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             homed_o;
  logic [POS_W-1:0] pos_o;

  typedef struct packed {
    logic             is_err;
    logic [POS_W-1:0] pos;
    logic             homed;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks_total  = 0;
  int   checks_passed = 0;

  track_position_ctrl #(
    .POS_W(POS_W), .MAX_POS(MAX_POS), .STEP_CYCLES(STEP_CYCLES),
    .SETTLE_STEPS(SETTLE_STEPS), .HOME_TIMEOUT(HOME_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_pos_i(cmd_pos_i), .home_i(home_i), .limit_i(limit_i), .move_o(move_o),
    .back_o(back_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .homed_o(homed_o), .pos_o(pos_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one request for a single cycle and records the outcome it should produce.
  task automatic applyStimulus(input logic home, input logic valid, input int pos,
                               input logic want, input logic is_err, input int exp_pos,
                               input logic exp_homed);
    exp_t e;
    @(negedge clk);
    home_i      = home;
    cmd_valid_i = valid;
    cmd_pos_i   = POS_W'(pos);
    if (want) begin
      e.is_err = is_err;
      e.pos    = POS_W'(exp_pos);
      e.homed  = exp_homed;
      exp_q.push_back(e);
    end
    @(negedge clk);
    home_i      = 1'b0;
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n < 400), 1);
  endtask

  task automatic countMove(input string name, input int expected);
    int n = 0;
    while (move_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, n, expected);
  endtask

  always @(negedge clk) begin
    if (rst_n && (done_o || err_o)) begin
      checkOutput("done_err_exclusive", 32'(done_o & err_o), 0);
      checkOutput("pending_expect", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("resp_is_err", 32'(err_o), 32'(mon_e.is_err));
        checkOutput("resp_pos", 32'(pos_o), 32'(mon_e.pos));
        checkOutput("resp_homed", 32'(homed_o), 32'(mon_e.homed));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_move", 32'(move_o), 0);
    checkOutput("reset_back", 32'(back_o), 0);
    checkOutput("reset_busy", 32'(busy_o), 0);
    checkOutput("reset_homed", 32'(homed_o), 0);
    checkOutput("reset_pos", 32'(pos_o), 0);
    checkOutput("reset_ready", 32'(cmd_ready_o), 1);

    // Command before homing is rejected.
    applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("unhomed_no_move", 32'(move_o), 0);
    waitIdle("unhomed_idle");

    // Homing with the limit arriving 24 clocks in.
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
    checkOutput("homing_move", 32'(move_o), 1);
    checkOutput("homing_back", 32'(back_o), 1);
    repeat (23) @(negedge clk);
    limit_i = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("homing_move_before_sync", 32'(move_o), 1);
    @(negedge clk);
    checkOutput("homing_move_fall", 32'(move_o), 0);
    checkOutput("homing_back_held", 32'(back_o), 1);
    repeat (7) @(negedge clk);
    checkOutput("settle_no_early_done", 32'(done_o), 0);
    @(negedge clk);
    checkOutput("settle_done_at_8", 32'(done_o), 1);
    limit_i = 1'b0;
    waitIdle("homing_idle");

    // Forward 0 -> 7, then backward 7 -> 3.
    applyStimulus(1'b0, 1'b1, 7, 1'b1, 1'b0, 7, 1'b1);
    checkOutput("fwd_back_low", 32'(back_o), 0);
    countMove("fwd_move_len", 28);
    checkOutput("fwd_pos", 32'(pos_o), 7);
    waitIdle("fwd_idle");

    applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1);
    checkOutput("bwd_back_high", 32'(back_o), 1);
    countMove("bwd_move_len", 16);
    checkOutput("bwd_pos", 32'(pos_o), 3);
    waitIdle("bwd_idle");

    // Same position completes immediately; out-of-range is rejected.
    applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b0, 3, 1'b1);
    checkOutput("same_pos_no_move", 32'(move_o), 0);
    checkOutput("same_pos_not_busy", 32'(busy_o), 0);
    waitIdle("same_pos_idle");
    applyStimulus(1'b0, 1'b1, 21, 1'b1, 1'b1, 3, 1'b1);
    checkOutput("range_no_move", 32'(move_o), 0);
    waitIdle("range_idle");

    // Homing timeout without any limit.
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 3, 1'b0);
    countMove("timeout_move_len", 120);
    checkOutput("timeout_homed", 32'(homed_o), 0);
    waitIdle("timeout_idle");

    // Re-home with the limit already active, then reset in the middle of a forward move.
    limit_i = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
    waitIdle("rehome_idle");
    limit_i = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 10, 1'b0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("midfwd_pos", 32'(pos_o), 2);
    checkOutput("midfwd_move", 32'(move_o), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_move", 32'(move_o), 0);
    checkOutput("midreset_busy", 32'(busy_o), 0);
    checkOutput("midreset_pos", 32'(pos_o), 0);
    checkOutput("midreset_homed", 32'(homed_o), 0);
    checkOutput("midreset_done_err", 32'(done_o | err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Home and command together: homing wins and the command is dropped.
    limit_i = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 1'b1);
    checkOutput("both_ready_low", 32'(cmd_ready_o), 0);
    checkOutput("both_no_pulse", 32'(done_o | err_o), 0);
    waitIdle("both_idle");
    limit_i = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
